phys_free_list: RTL and testbench

- Circular free list of physical register tags feeding the rename stage.
- Supplies up to two new destination tags per cycle; these go to the rename map table write ports (w0/w1 phys reg) and the retirement map.
- Commit returns previously mapped tags.
- Flush rewinds speculative allocations to the committed point.

---
 rtl/phys_free_list_pkg.sv | 22 ++
 rtl/phys_free_list_if.sv | 28 ++
 rtl/phys_free_list_fl_ram.sv | 43 ++++
 rtl/phys_free_list.sv | 132 +++++++++++++
 tb/tb_phys_free_list.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/phys_free_list_pkg.sv
// Shared rename-stage definitions for the physical register free list.
// Holds the register-file sizing constants, the tag type and a small
// population-count helper used for pointer arithmetic.
package phys_free_list_pkg;

  localparam int PRF_ENTRIES = 64;
  localparam int ARCH_REGS   = 32;
  localparam int TAG_W       = $clog2(PRF_ENTRIES);
  localparam int FL_DEPTH    = PRF_ENTRIES - ARCH_REGS;
  localparam int FL_IDX_W    = $clog2(FL_DEPTH);
  // One extra pointer bit acts as the wrap flag so full and empty differ.
  localparam int PTR_W       = FL_IDX_W + 1;

  typedef logic [TAG_W-1:0] preg_t;
  typedef logic [PTR_W-1:0] ptr_t;

  // Number of set bits in a two-slot request/valid vector, pointer-wide.
  function automatic ptr_t popcnt2(input logic [1:0] v);
    return ptr_t'(v[0]) + ptr_t'(v[1]);
  endfunction

endpackage

// File: rtl/phys_free_list_if.sv
// Handshake bundle between the rename/commit logic and the free list.
// master: rename+commit side (drives requests, frees, flush)
// slave : free list (returns ready, tags and the speculative free count)
interface phys_free_list_if;
  import phys_free_list_pkg::*;

  logic [1:0] alloc_req_i;
  logic       alloc_ready_o;
  preg_t      alloc0_preg_o;
  preg_t      alloc1_preg_o;
  logic [1:0] commit_alloc_i;
  logic [1:0] free_we_i;
  preg_t      free0_preg_i;
  preg_t      free1_preg_i;
  logic       flush_i;
  ptr_t       free_count_o;

  modport master (
    output alloc_req_i, commit_alloc_i, free_we_i, free0_preg_i, free1_preg_i, flush_i,
    input  alloc_ready_o, alloc0_preg_o, alloc1_preg_o, free_count_o
  );

  modport slave (
    input  alloc_req_i, commit_alloc_i, free_we_i, free0_preg_i, free1_preg_i, flush_i,
    output alloc_ready_o, alloc0_preg_o, alloc1_preg_o, free_count_o
  );

endinterface

// File: rtl/phys_free_list_fl_ram.sv
// Free-list storage: FL_DEPTH x TAG_W memory with two asynchronous read
// ports and two write ports. Reset reloads entry i with tag ARCH_REGS+i.
// Ports: clk, rst (sync, active high), rd0/rd1 index+data,
//        we0/wa0/wd0 and we1/wa1/wd1 write ports (port 1 wins on collision).
module phys_free_list_fl_ram
  import phys_free_list_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [FL_IDX_W-1:0] rd0_idx,
  input  logic [FL_IDX_W-1:0] rd1_idx,
  output preg_t               rd0_data,
  output preg_t               rd1_data,
  input  logic                we0,
  input  logic [FL_IDX_W-1:0] wa0,
  input  preg_t               wd0,
  input  logic                we1,
  input  logic [FL_IDX_W-1:0] wa1,
  input  preg_t               wd1
);

  preg_t mem [FL_DEPTH];

  assign rd0_data = mem[rd0_idx];
  assign rd1_data = mem[rd1_idx];

  // Reset restores the full initial list; otherwise apply the free writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FL_DEPTH; i++) begin
        mem[i] <= preg_t'(ARCH_REGS + i);
      end
    end else begin
      if (we0) begin
        mem[wa0] <= wd0;
      end
      if (we1) begin
        mem[wa1] <= wd1;
      end
    end
  end

endmodule

// File: rtl/phys_free_list.sv
// Circular free list of physical register tags for the rename stage.
// Hands out up to two tags per cycle with zero latency, takes back up to
// two released tags per cycle at the tail, and on flush rewinds the
// speculative head to the committed head.
// Ports: cpu_clk_i, cpu_rst_i (sync, active high), fl_if (slave modport).
module phys_free_list
  import phys_free_list_pkg::*;
(
  input  logic             cpu_clk_i,
  input  logic             cpu_rst_i,
  phys_free_list_if.slave  fl_if
);

  ptr_t head_r;
  ptr_t tail_r;
  ptr_t chead_r;

  ptr_t                count_s;
  ptr_t                need_s;
  logic                ready_s;
  logic                fire_s;
  logic [FL_IDX_W-1:0] head_idx_p1_s;
  logic [FL_IDX_W-1:0] tail_idx_p1_s;
  logic [FL_IDX_W-1:0] rd1_idx_s;
  logic [FL_IDX_W-1:0] wa1_s;

  // Ready and tags depend only on registered state, so same-cycle frees
  // never feed same-cycle allocations.
  always_comb begin
    count_s       = tail_r - head_r;
    need_s        = popcnt2(fl_if.alloc_req_i);
    ready_s       = (count_s >= need_s);
    fire_s        = (|fl_if.alloc_req_i) & ready_s & ~fl_if.flush_i;
    head_idx_p1_s = head_r[FL_IDX_W-1:0] + FL_IDX_W'(1);
    tail_idx_p1_s = tail_r[FL_IDX_W-1:0] + FL_IDX_W'(1);
    // A lone slot1 request takes the head entry rather than head+1.
    if (fl_if.alloc_req_i[0]) begin
      rd1_idx_s = head_idx_p1_s;
    end else begin
      rd1_idx_s = head_r[FL_IDX_W-1:0];
    end
    // A lone port-1 free lands at the tail itself.
    if (fl_if.free_we_i[0]) begin
      wa1_s = tail_idx_p1_s;
    end else begin
      wa1_s = tail_r[FL_IDX_W-1:0];
    end
  end

  assign fl_if.alloc_ready_o = ready_s;
  assign fl_if.free_count_o  = count_s;

  phys_free_list_fl_ram u_fl_ram (
    .clk      (cpu_clk_i),
    .rst      (cpu_rst_i),
    .rd0_idx  (head_r[FL_IDX_W-1:0]),
    .rd1_idx  (rd1_idx_s),
    .rd0_data (fl_if.alloc0_preg_o),
    .rd1_data (fl_if.alloc1_preg_o),
    .we0      (fl_if.free_we_i[0]),
    .wa0      (tail_r[FL_IDX_W-1:0]),
    .wd0      (fl_if.free0_preg_i),
    .we1      (fl_if.free_we_i[1]),
    .wa1      (wa1_s),
    .wd1      (fl_if.free1_preg_i)
  );

  // Pointer update: reset over flush over allocation; frees and commits
  // proceed independently of allocation.
  always_ff @(posedge cpu_clk_i) begin
    if (cpu_rst_i) begin
      head_r  <= ptr_t'(0);
      chead_r <= ptr_t'(0);
      tail_r  <= ptr_t'(FL_DEPTH);
    end else begin
      tail_r  <= tail_r + popcnt2(fl_if.free_we_i);
      chead_r <= chead_r + ptr_t'(fl_if.commit_alloc_i);
      if (fl_if.flush_i) begin
        // Commits retiring in the flush cycle still count as committed.
        head_r <= chead_r + ptr_t'(fl_if.commit_alloc_i);
      end else if (fire_s) begin
        head_r <= head_r + need_s;
      end else begin
        head_r <= head_r;
      end
    end
  end

  phys_free_list_chk u_chk (
    .clk          (cpu_clk_i),
    .rst          (cpu_rst_i),
    .head         (head_r),
    .chead        (chead_r),
    .count        (count_s),
    .free_we      (fl_if.free_we_i),
    .commit_alloc (fl_if.commit_alloc_i)
  );

endmodule

// Simulation-only invariant checker for the free list pointers.
// Ports: clk, rst, head/chead pointers, speculative count, free valids,
// commit count.
module phys_free_list_chk
  import phys_free_list_pkg::*;
(
  input logic       clk,
  input logic       rst,
  input ptr_t       head,
  input ptr_t       chead,
  input ptr_t       count,
  input logic [1:0] free_we,
  input logic [1:0] commit_alloc
);

  a_count_max: assert property (@(posedge clk) disable iff (rst)
    count <= ptr_t'(FL_DEPTH))
    else $error("free list count above depth");

  a_free_room: assert property (@(posedge clk) disable iff (rst)
    ({1'b0, count} + {1'b0, popcnt2(free_we)}) <= (PTR_W+1)'(FL_DEPTH))
    else $error("free list overfilled by frees");

  a_chead_order: assert property (@(posedge clk) disable iff (rst)
    ptr_t'(head - chead) <= ptr_t'(FL_DEPTH))
    else $error("committed head passed speculative head");

  a_commit_range: assert property (@(posedge clk) disable iff (rst)
    commit_alloc != 2'd3)
    else $error("commit count of three");

endmodule

// File: tb/tb_phys_free_list.sv
// Self-checking bench for phys_free_list: directed steps followed by
// randomized traffic, both compared against a queue-based model in which
// the free list is an ordered queue of tags and in-flight allocations are
// a second queue returned to the front on flush.
module tb_phys_free_list;
  import phys_free_list_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  phys_free_list_if bus ();

  phys_free_list dut (
    .cpu_clk_i (clk),
    .cpu_rst_i (rst),
    .fl_if     (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int free_q[$];
  int spec_q[$];
  bit model_ok = 1'b0;

  logic [1:0] cur_req, cur_cm, cur_fwe;
  int         cur_t0, cur_t1;
  logic       cur_fl, cur_rst;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    free_q.delete();
    spec_q.delete();
    for (int i = 0; i < 32; i++) free_q.push_back(32 + i);
    model_ok = 1'b1;
  endtask

  // Apply inputs for this cycle and compare outputs against the model.
  task automatic drive(input logic [1:0] req, input logic [1:0] cm, input logic [1:0] fwe,
                       input int t0, input int t1, input logic fl, input logic r);
    int need;
    cur_req = req; cur_cm = cm; cur_fwe = fwe;
    cur_t0 = t0; cur_t1 = t1; cur_fl = fl; cur_rst = r;
    bus.alloc_req_i    = req;
    bus.commit_alloc_i = cm;
    bus.free_we_i      = fwe;
    bus.free0_preg_i   = preg_t'(t0);
    bus.free1_preg_i   = preg_t'(t1);
    bus.flush_i        = fl;
    rst                = r;
    #1;
    if (model_ok) begin
      need = int'(req[0]) + int'(req[1]);
      check("ready", 32'(bus.alloc_ready_o), 32'(free_q.size() >= need));
      check("count", 32'(bus.free_count_o), 32'(free_q.size()));
      if (free_q.size() >= 1) check("alloc0", 32'(bus.alloc0_preg_o), 32'(free_q[0]));
      if (req[0] && free_q.size() >= 2) check("alloc1", 32'(bus.alloc1_preg_o), 32'(free_q[1]));
      if (!req[0] && free_q.size() >= 1) check("alloc1", 32'(bus.alloc1_preg_o), 32'(free_q[0]));
    end
  endtask

  // Advance the model by the driven cycle and clock the DUT.
  task automatic tick();
    int need;
    int v;
    bit fire;
    if (cur_rst) begin
      model_reset();
    end else begin
      need = int'(cur_req[0]) + int'(cur_req[1]);
      fire = (cur_req != 2'b00) && (free_q.size() >= need) && !cur_fl;
      for (int i = 0; i < int'(cur_cm); i++) v = spec_q.pop_front();
      if (fire) for (int i = 0; i < need; i++) spec_q.push_back(free_q.pop_front());
      if (cur_fwe[0]) free_q.push_back(cur_t0);
      if (cur_fwe[1]) free_q.push_back(cur_t1);
      if (cur_fl) begin
        while (spec_q.size() > 0) free_q.push_front(spec_q.pop_back());
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] rq, cmv, fw;
    int room, maxc, pc;

    // Reset
    drive(2'b00, 2'b00, 2'b00, 0, 0, 1'b0, 1'b1); tick();

    // First dual allocation from the reset list
    drive(2'b11, 2'b00, 2'b00, 0, 0, 1'b0, 1'b0);
    check("t1_count", 32'(bus.free_count_o), 32'd32);
    check("t1_ready", 32'(bus.alloc_ready_o), 32'd1);
    check("t1_a0", 32'(bus.alloc0_preg_o), 32'd32);
    check("t1_a1", 32'(bus.alloc1_preg_o), 32'd33);
    tick();
    drive(2'b11, 2'b00, 2'b00, 0, 0, 1'b0, 1'b0);
    check("t1_count2", 32'(bus.free_count_o), 32'd30);
    check("t1_a0_2", 32'(bus.alloc0_preg_o), 32'd34);
    check("t1_a1_2", 32'(bus.alloc1_preg_o), 32'd35);
    tick();

    // Drain to empty, then a single request must stall
    repeat (14) begin drive(2'b11, 2'b00, 2'b00, 0, 0, 1'b0, 1'b0); tick(); end
    drive(2'b01, 2'b00, 2'b00, 0, 0, 1'b0, 1'b0);
    check("t2_count", 32'(bus.free_count_o), 32'd0);
    check("t2_ready", 32'(bus.alloc_ready_o), 32'd0);
    tick();

    // Free 5 and 9 while empty; not visible until next cycle
    drive(2'b01, 2'b00, 2'b11, 5, 9, 1'b0, 1'b0);
    check("t2_hold", 32'(bus.free_count_o), 32'd0);
    tick();
    drive(2'b11, 2'b00, 2'b00, 0, 0, 1'b0, 1'b0);
    check("t3_count", 32'(bus.free_count_o), 32'd2);
    check("t3_a0", 32'(bus.alloc0_preg_o), 32'd5);
    check("t3_a1", 32'(bus.alloc1_preg_o), 32'd9);
    drive(2'b10, 2'b00, 2'b00, 0, 0, 1'b0, 1'b0);
    check("t3_slot1_head", 32'(bus.alloc1_preg_o), 32'd5);
    tick();

    // Allocate six, commit two, flush
    drive(2'b00, 2'b00, 2'b00, 0, 0, 1'b0, 1'b1); tick();
    repeat (3) begin drive(2'b11, 2'b00, 2'b00, 0, 0, 1'b0, 1'b0); tick(); end
    drive(2'b00, 2'b10, 2'b00, 0, 0, 1'b0, 1'b0); tick();
    drive(2'b11, 2'b00, 2'b00, 0, 0, 1'b1, 1'b0); tick();
    drive(2'b00, 2'b00, 2'b00, 0, 0, 1'b0, 1'b0);
    check("t4_count", 32'(bus.free_count_o), 32'd30);
    check("t4_a0", 32'(bus.alloc0_preg_o), 32'd34);
    tick();

    // Flush with same-cycle commit and free of tag 3
    repeat (2) begin drive(2'b11, 2'b00, 2'b00, 0, 0, 1'b0, 1'b0); tick(); end
    drive(2'b00, 2'b10, 2'b00, 0, 0, 1'b0, 1'b0); tick();
    drive(2'b11, 2'b01, 2'b01, 3, 0, 1'b1, 1'b0); tick();
    drive(2'b00, 2'b00, 2'b00, 0, 0, 1'b0, 1'b0);
    check("t5_count", 32'(bus.free_count_o), 32'd28);
    check("t5_a0", 32'(bus.alloc0_preg_o), 32'd37);
    tick();
    repeat (13) begin drive(2'b11, 2'b00, 2'b00, 0, 0, 1'b0, 1'b0); tick(); end
    drive(2'b11, 2'b00, 2'b00, 0, 0, 1'b0, 1'b0);
    check("t5_last_a0", 32'(bus.alloc0_preg_o), 32'd63);
    check("t5_freed_tag", 32'(bus.alloc1_preg_o), 32'd3);
    tick();

    // Reset dominates a same-cycle flush and allocation
    drive(2'b00, 2'b00, 2'b00, 0, 0, 1'b0, 1'b1); tick();
    repeat (11) begin drive(2'b11, 2'b00, 2'b00, 0, 0, 1'b0, 1'b0); tick(); end
    drive(2'b11, 2'b00, 2'b00, 0, 0, 1'b1, 1'b1);
    check("t6_count_pre", 32'(bus.free_count_o), 32'd10);
    tick();
    drive(2'b11, 2'b00, 2'b00, 0, 0, 1'b0, 1'b0);
    check("t6_count", 32'(bus.free_count_o), 32'd32);
    check("t6_a0", 32'(bus.alloc0_preg_o), 32'd32);
    check("t6_a1", 32'(bus.alloc1_preg_o), 32'd33);
    tick();

    // Randomized legal traffic
    drive(2'b00, 2'b00, 2'b00, 0, 0, 1'b0, 1'b1); tick();
    for (int it = 0; it < 3000; it++) begin
      rq   = 2'($urandom_range(0, 3));
      maxc = (spec_q.size() < 2) ? spec_q.size() : 2;
      cmv  = 2'($urandom_range(0, maxc));
      fw   = 2'($urandom_range(0, 3));
      pc   = int'(fw[0]) + int'(fw[1]);
      room = 32 - free_q.size() - spec_q.size();
      if (pc > room) fw = 2'b00;
      drive(rq, cmv, fw, int'($urandom_range(0, 63)), int'($urandom_range(0, 63)),
            ($urandom_range(0, 15) == 0), ($urandom_range(0, 299) == 0));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
